// File: rtl/req_encoder.sv
// req_encoder
//   Turns a multi-hot request vector into a stream of binary indices, lowest
//   set bit first, one index per output handshake. It is the inverse companion
//   of the 2-to-4 one-hot decoder.
//
//   Parameters
//     N  width of the request vector (N >= 2)
//     W  width of the output index   (N <= 2**W)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   in_req is presented
//     in_ready   block can accept a vector (IDLE only)
//     in_req     request vector, bit i set requests index i
//     out_valid  out_idx is valid (SEND only)
//     out_ready  downstream accepts the current index
//     out_idx    binary index of the lowest pending bit
//     out_last   current index is the final one of this vector
//     zero_err   one-cycle pulse after an all-zero vector is accepted
//
//   Every output is decoded from registered state only, so there is no
//   combinational path from in_* or out_ready to any output.
module req_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_err
);

  if ((N < 2) || (N > (1 << W))) begin : g_bad_cfg
    $error("req_encoder: N=%0d does not fit W=%0d (need 2 <= N <= 2**W)", N, W);
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Position of the lowest set bit, zero-extended to W bits; 0 when none set.
  function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // Clearing the lowest set bit is v & (v-1); no index decode needed.
  function automatic logic [N-1:0] drop_lowest(input logic [N-1:0] v);
    return v & (v - N'(1));
  endfunction

  state_t         state, state_nxt;
  logic [N-1:0]   pending, pending_nxt;
  logic           zero_err_q, zero_err_nxt;
  logic           accept;
  logic           beat;

  assign accept = (state == IDLE) && in_valid;
  assign beat   = (state == SEND) && out_ready;

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    zero_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_req == '0) begin
            zero_err_nxt = 1'b1;
          end else begin
            pending_nxt = in_req;
            state_nxt   = SEND;
          end
        end
      end
      SEND: begin
        if (beat) begin
          pending_nxt = drop_lowest(pending);
          // Leaving on the final beat; pending is left all-zero so the
          // decoded index reads 0 while idle.
          if (is_single(pending)) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  // ---- state register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      zero_err_q <= zero_err_nxt;
    end
  end

  // ---- output decode from registered state ----
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);
  assign out_idx   = lowest_idx(pending);
  assign out_last  = is_single(pending);
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_req_encoder.sv
module tb_req_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  req_encoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full output snapshot: valid, ready, idx, last, zero_err.
  task automatic expect_out(input string tag, input logic v, input logic r,
                            input logic [W-1:0] idx, input logic last, input logic ze);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".in_ready"},  32'(in_ready),  32'(r));
    check({tag, ".out_idx"},   32'(out_idx),   32'(idx));
    check({tag, ".out_last"},  32'(out_last),  32'(last));
    check({tag, ".zero_err"},  32'(zero_err),  32'(ze));
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("excl_ready_valid", 32'(in_ready & out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b1;

    // Reset held with clock running.
    repeat (3) tick();
    expect_out("reset_hold", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out("reset_release", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Single bit 0100 -> idx 2, last.
    in_valid = 1'b1;
    in_req   = 4'b0100;
    tick();
    in_valid = 1'b0;
    expect_out("single.beat", 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
    tick();
    expect_out("single.idle", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Multi-bit 1011 -> 0, 1, 3.
    in_valid = 1'b1;
    in_req   = 4'b1011;
    tick();
    in_valid = 1'b0;
    expect_out("multi.b0", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("multi.b1", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("multi.b2", 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    tick();
    expect_out("multi.idle", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Backpressure 0110, stalled 3 cycles, in_req changed during SEND.
    in_valid  = 1'b1;
    in_req    = 4'b0110;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_req   = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      expect_out("bp.stall", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
      in_req = 4'(k + 8);
      tick();
    end
    out_ready = 1'b1;
    expect_out("bp.go_b0", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("bp.b1", 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
    tick();
    expect_out("bp.idle", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Zero vector, then 1000 accepted on the very next cycle.
    in_valid = 1'b1;
    in_req   = 4'b0000;
    tick();
    expect_out("zero.pulse", 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    in_req = 4'b1000;
    tick();
    in_valid = 1'b0;
    expect_out("zero.next_vec", 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    tick();
    expect_out("zero.idle", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Reset mid-vector 1111 after idx 1 has been sent.
    in_valid = 1'b1;
    in_req   = 4'b1111;
    tick();
    in_valid = 1'b0;
    expect_out("rst_mid.b0", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst_mid.b1", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("rst_mid.b2", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst_mid.async", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst_mid.held", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_req   = 4'b0001;
    tick();
    in_valid = 1'b0;
    expect_out("rst_mid.new", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    expect_out("rst_mid.idle", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("rst_mid.no_stale", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
